// File: rtl/keypad_event_fifo.sv
// Keypad event FIFO: serialises one-cycle key pulses into 4-bit codes (lowest index first)
// and buffers them in a show-ahead FIFO with read-pop, level interrupt and sticky overflow.
module keypad_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      key_pulse,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [3:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             key_irq,
  output logic             overflow,
  output logic [15:0]      pending
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [15:0]      pending_reg, pending_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic             overflow_reg, overflow_next;
  logic [3:0]       mem [DEPTH];

  logic [3:0]  sel;
  logic [15:0] clr_mask;
  logic        push, pop, drop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push    = (pending_reg != '0) && (!full || pop);

  // Lowest set bit of the registered pending vector wins.
  always_comb begin
    sel = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_reg[i]) sel = 4'(i);
    end
  end

  assign clr_mask = push ? (16'd1 << sel) : 16'd0;
  // A press is lost only if its bit is still pending and not being drained this cycle.
  assign drop     = |(key_pulse & pending_reg & ~clr_mask);

  always_comb begin
    pending_next  = (pending_reg & ~clr_mask) | key_pulse;
    overflow_next = overflow_reg;
    if (ovf_clr) overflow_next = 1'b0;
    if (drop)    overflow_next = 1'b1;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= '0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // Storage carries no reset; empty gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= sel;
  end

  assign rd_data  = empty ? 4'd0 : mem[rd_ptr_reg];
  assign count    = count_reg;
  assign key_irq  = !empty;
  assign overflow = overflow_reg;
  assign pending  = pending_reg;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Directed self-checking bench for keypad_event_fifo (DEPTH=8).
module tb_keypad_event_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_pulse;
  logic        rd_en;
  logic        ovf_clr;
  logic [3:0]  rd_data;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        key_irq;
  logic        overflow;
  logic [15:0] pending;

  int checks   = 0;
  int failures = 0;

  keypad_event_fifo #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .key_irq   (key_irq),
    .overflow  (overflow),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] drain_exp [9];

  initial begin
    drain_exp[0] = 4'd1; drain_exp[1] = 4'd2; drain_exp[2] = 4'd3;
    drain_exp[3] = 4'd4; drain_exp[4] = 4'd5; drain_exp[5] = 4'd6;
    drain_exp[6] = 4'd7; drain_exp[7] = 4'd9; drain_exp[8] = 4'd3;

    rst = 1'b1; key_pulse = 16'h0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_irq",      32'(key_irq),  32'd0);
    check("rst_ovf",      32'(overflow), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_pending",  32'(pending),  32'd0);
    rst = 1'b0;
    tick();

    // 1: single press latency
    key_pulse = 16'h0020;
    tick();
    key_pulse = 16'h0;
    check("t1_pending_e0", 32'(pending), 32'h0020);
    check("t1_empty_e0",   32'(empty),   32'd1);
    tick();
    check("t1_empty",   32'(empty),   32'd0);
    check("t1_rd_data", 32'(rd_data), 32'd5);
    check("t1_irq",     32'(key_irq), 32'd1);
    check("t1_count",   32'(count),   32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t1_pop_empty", 32'(empty),   32'd1);
    check("t1_pop_irq",   32'(key_irq), 32'd0);

    // 2: simultaneous presses serialised lowest first
    key_pulse = 16'h8101;
    tick();
    key_pulse = 16'h0;
    tick();
    check("t2_count1", 32'(count), 32'd1);
    check("t2_pend1",  32'(pending), 32'h8100);
    tick(); tick();
    check("t2_count3", 32'(count), 32'd3);
    check("t2_pend0",  32'(pending), 32'h0);
    check("t2_head0",  32'(rd_data), 32'd0);
    rd_en = 1'b1;
    tick();
    check("t2_head8",  32'(rd_data), 32'd8);
    tick();
    check("t2_head15", 32'(rd_data), 32'd15);
    tick();
    rd_en = 1'b0;
    check("t2_empty",  32'(empty), 32'd1);

    // 3: fill, stall pending while full, push-on-pop at full
    key_pulse = 16'h00FF;
    tick();
    key_pulse = 16'h0;
    for (int i = 0; i < 8; i++) tick();
    check("t3_full",  32'(full),  32'd1);
    check("t3_count", 32'(count), 32'd8);
    key_pulse = 16'h0200;
    tick();
    key_pulse = 16'h0;
    tick();
    check("t3_pend_stall", 32'(pending),  32'h0200);
    check("t3_full_stall", 32'(full),     32'd1);
    check("t3_no_ovf",     32'(overflow), 32'd0);
    check("t3_head",       32'(rd_data),  32'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_count_pp", 32'(count),   32'd8);
    check("t3_pend_pp",  32'(pending), 32'h0);
    check("t3_head_pp",  32'(rd_data), 32'd1);

    // 4: overflow set, clear, and drop-beats-clear
    key_pulse = 16'h0008;
    tick();
    check("t4_no_ovf_first", 32'(overflow), 32'd0);
    tick();
    key_pulse = 16'h0;
    check("t4_ovf_set",  32'(overflow), 32'd1);
    check("t4_pend",     32'(pending),  32'h0008);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr",  32'(overflow), 32'd0);
    ovf_clr = 1'b1; key_pulse = 16'h0008;
    tick();
    ovf_clr = 1'b0; key_pulse = 16'h0;
    check("t4_ovf_wins", 32'(overflow), 32'd1);
    rd_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t4_drain%0d", i), 32'(rd_data), 32'(drain_exp[i]));
      tick();
    end
    rd_en = 1'b0;
    check("t4_drain_empty", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // Re-press of the bit being drained this cycle is kept, not dropped
    key_pulse = 16'h0004;
    tick();
    tick();
    key_pulse = 16'h0;
    check("t4b_pend_reset", 32'(pending),  32'h0004);
    check("t4b_no_ovf",     32'(overflow), 32'd0);
    tick();
    check("t4b_count",      32'(count),    32'd2);
    rd_en = 1'b1;
    check("t4b_head_a", 32'(rd_data), 32'd2);
    tick();
    check("t4b_head_b", 32'(rd_data), 32'd2);
    tick();
    rd_en = 1'b0;
    check("t4b_empty", 32'(empty), 32'd1);

    // 5: rd_en while empty is ignored
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t5_idle_count%0d", i), 32'(count), 32'd0);
    end
    key_pulse = 16'h1000;
    tick();
    key_pulse = 16'h0;
    tick();
    check("t5_empty",   32'(empty),   32'd0);
    check("t5_rd_data", 32'(rd_data), 32'd12);
    check("t5_count",   32'(count),   32'd1);
    tick();
    rd_en = 1'b0;
    check("t5_popped",  32'(empty),   32'd1);
    check("t5_count0",  32'(count),   32'd0);

    // 6: asynchronous reset mid-burst
    key_pulse = 16'h00FF;
    tick();
    key_pulse = 16'h0;
    for (int i = 0; i < 5; i++) tick();
    check("t6_count5", 32'(count),   32'd5);
    check("t6_pend",   32'(pending), 32'h00E0);
    key_pulse = 16'h0080;
    tick();
    key_pulse = 16'h0;
    check("t6_ovf_pre", 32'(overflow), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_count",   32'(count),    32'd0);
    check("t6_empty",   32'(empty),    32'd1);
    check("t6_pending", 32'(pending),  32'h0);
    check("t6_ovf",     32'(overflow), 32'd0);
    check("t6_rd_data", 32'(rd_data),  32'd0);
    check("t6_irq",     32'(key_irq),  32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
